uart_line_echo: RTL and testbench

//   Echo engine between uart_fifo and the board pins, replacing the fixed byte echo.
//   Two runtime modes: byte echo, or line echo with an internal buffer, backspace

---
 rtl/uart_line_echo_if.sv | 27 ++
 rtl/uart_line_echo.sv | 181 ++++++++++++++++++
 tb/tb_uart_line_echo.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_line_echo_if.sv
// Purpose: byte handshake between the echo engine and the rx/tx FIFOs of uart_fifo.
// Signals:
//   rx_byte, rx_fifo_empty  rx FIFO head (first-word fall-through) and empty flag
//   rx_fifo_pop             one-cycle pop strobe into the rx FIFO
//   tx_byte, transmit       byte and one-cycle push strobe into the tx FIFO
//   tx_fifo_full            tx FIFO full flag
// Modports: master = echo engine, slave = FIFO side.
interface uart_line_echo_if #(
    parameter int unsigned DATA_W = 8
);
    logic [DATA_W-1:0] rx_byte;
    logic              rx_fifo_empty;
    logic              rx_fifo_pop;
    logic [DATA_W-1:0] tx_byte;
    logic              transmit;
    logic              tx_fifo_full;

    modport master (
        input  rx_byte, rx_fifo_empty, tx_fifo_full,
        output rx_fifo_pop, tx_byte, transmit
    );

    modport slave (
        output rx_byte, rx_fifo_empty, tx_fifo_full,
        input  rx_fifo_pop, tx_byte, transmit
    );
endinterface

// File: rtl/uart_line_echo.sv
// Purpose: echo engine between uart_fifo and the pins. Byte echo, or line echo with
// an internal buffer, backspace editing and a CR/LF terminator; optional upper-casing.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   line_mode    0 = byte echo, 1 = line echo (takes effect only while the buffer is empty)
//   upcase       map 'a'..'z' to 'A'..'Z' on transmit
//   clr_ovf      synchronous clear of ovf (a same-cycle set wins)
//   bus          FIFO handshake (master side)
//   busy         engine is outside IDLE
//   line_done    one-cycle pulse together with the LF of a flushed line
//   ovf          sticky: a byte was dropped on a full line buffer
//   fill         line buffer count, 0..LINE_DEPTH
module uart_line_echo #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned LINE_DEPTH = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         line_mode,
    input  logic                         upcase,
    input  logic                         clr_ovf,
    uart_line_echo_if.master             bus,
    output logic                         busy,
    output logic                         line_done,
    output logic                         ovf,
    output logic [$clog2(LINE_DEPTH):0]  fill
);
    localparam int unsigned CNT_W = $clog2(LINE_DEPTH) + 1;
    localparam int unsigned IDX_W = $clog2(LINE_DEPTH);

    localparam logic [DATA_W-1:0] CH_CR = DATA_W'(8'h0D);
    localparam logic [DATA_W-1:0] CH_LF = DATA_W'(8'h0A);
    localparam logic [DATA_W-1:0] CH_BS = DATA_W'(8'h08);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        BYTE_GAP  = 3'd1,
        FLUSH     = 3'd2,
        FLUSH_GAP = 3'd3,
        SEND_CR   = 3'd4,
        SEND_LF   = 3'd5
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  rd_idx;
    logic [DATA_W-1:0] line_mem [LINE_DEPTH];

    logic strobe_ok_c;
    logic line_eff_c;
    logic rx_is_cr_c;
    logic rx_is_bs_c;
    logic line_pop_c;
    logic buf_full_c;
    logic wr_en_c;
    logic ovf_set_c;

    // Upper-case letters only in bits [7:0]; clearing bit 5 maps 0x61..0x7A to 0x41..0x5A.
    function automatic logic [DATA_W-1:0] xform(input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] r;
        r = d;
        if (upcase && (d[7:0] >= 8'h61) && (d[7:0] <= 8'h7A)) begin
            r[5] = 1'b0;
        end
        return r;
    endfunction

    // A strobe registered last cycle blocks the next one, keeping strobes >= 2 cycles apart
    // and giving the rx FIFO a cycle to advance its head after a pop.
    assign strobe_ok_c = !bus.rx_fifo_pop && !bus.transmit;
    // A non-empty buffer pins line mode so buffered data is always flushed.
    assign line_eff_c  = line_mode || (fill != '0);
    assign rx_is_cr_c  = (bus.rx_byte == CH_CR);
    assign rx_is_bs_c  = (bus.rx_byte == CH_BS);
    assign line_pop_c  = (state == IDLE) && strobe_ok_c && !bus.rx_fifo_empty && line_eff_c;
    assign buf_full_c  = (fill == CNT_W'(LINE_DEPTH));
    assign wr_en_c     = line_pop_c && !rx_is_cr_c && !rx_is_bs_c && !buf_full_c;
    assign ovf_set_c   = line_pop_c && !rx_is_cr_c && !rx_is_bs_c && buf_full_c;

    // Line buffer storage; not reset. Write index equals fill (backspace moves both).
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            line_mem[fill[IDX_W-1:0]] <= bus.rx_byte;
        end
    end

    // Sticky overflow flag; set wins over clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (ovf_set_c) begin
            ovf <= 1'b1;
        end else if (clr_ovf) begin
            ovf <= 1'b0;
        end
    end

    // Echo FSM with registered strobes, data and status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            rd_idx          <= '0;
            fill            <= '0;
            busy            <= 1'b0;
            line_done       <= 1'b0;
            bus.rx_fifo_pop <= 1'b0;
            bus.transmit    <= 1'b0;
            bus.tx_byte     <= '0;
        end else begin
            bus.rx_fifo_pop <= 1'b0;
            bus.transmit    <= 1'b0;
            line_done       <= 1'b0;
            case (state)
                IDLE: begin
                    if (strobe_ok_c && !bus.rx_fifo_empty) begin
                        if (!line_eff_c) begin
                            if (!bus.tx_fifo_full) begin
                                bus.rx_fifo_pop <= 1'b1;
                                bus.transmit    <= 1'b1;
                                bus.tx_byte     <= xform(bus.rx_byte);
                                state           <= BYTE_GAP;
                                busy            <= 1'b1;
                            end
                        end else begin
                            bus.rx_fifo_pop <= 1'b1;
                            if (rx_is_cr_c) begin
                                rd_idx <= '0;
                                state  <= FLUSH;
                                busy   <= 1'b1;
                            end else if (rx_is_bs_c) begin
                                if (fill != '0) begin
                                    fill <= fill - CNT_W'(1);
                                end
                            end else if (!buf_full_c) begin
                                fill <= fill + CNT_W'(1);
                            end
                        end
                    end
                end
                BYTE_GAP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                FLUSH: begin
                    if (rd_idx == fill) begin
                        state <= SEND_CR;
                    end else if (strobe_ok_c && !bus.tx_fifo_full) begin
                        bus.transmit <= 1'b1;
                        bus.tx_byte  <= xform(line_mem[rd_idx[IDX_W-1:0]]);
                        rd_idx       <= rd_idx + CNT_W'(1);
                        state        <= FLUSH_GAP;
                    end
                end
                FLUSH_GAP: begin
                    state <= FLUSH;
                end
                SEND_CR: begin
                    if (strobe_ok_c && !bus.tx_fifo_full) begin
                        bus.transmit <= 1'b1;
                        bus.tx_byte  <= CH_CR;
                        state        <= SEND_LF;
                    end
                end
                SEND_LF: begin
                    if (strobe_ok_c && !bus.tx_fifo_full) begin
                        bus.transmit <= 1'b1;
                        bus.tx_byte  <= CH_LF;
                        line_done    <= 1'b1;
                        fill         <= '0;
                        rd_idx       <= '0;
                        state        <= IDLE;
                        busy         <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_line_echo.sv
// Purpose: directed self-checking bench for uart_line_echo with a small rx/tx FIFO model.
module tb_uart_line_echo;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned LINE_DEPTH = 4;
    localparam int unsigned CNT_W      = $clog2(LINE_DEPTH) + 1;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             line_mode = 1'b0;
    logic             upcase    = 1'b0;
    logic             clr_ovf   = 1'b0;
    logic             busy;
    logic             line_done;
    logic             ovf;
    logic [CNT_W-1:0] fill;

    uart_line_echo_if #(.DATA_W(DATA_W)) bus ();

    uart_line_echo #(
        .DATA_W     (DATA_W),
        .LINE_DEPTH (LINE_DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .line_mode (line_mode),
        .upcase    (upcase),
        .clr_ovf   (clr_ovf),
        .bus       (bus),
        .busy      (busy),
        .line_done (line_done),
        .ovf       (ovf),
        .fill      (fill)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // FIFO model: rx source list with read pointer, tx capture log, strobe rule monitors.
    logic [7:0] rx_src [$];
    logic [7:0] tx_log [$];
    logic [7:0] exp_q  [$];
    int         rd_ptr      = 0;
    int         pop_cnt     = 0;
    int         done_cnt    = 0;
    int         space_viol  = 0;
    int         full_viol   = 0;
    int         tog_cnt     = 0;
    logic       strobe_prev = 1'b0;
    logic       full_tog    = 1'b0;
    logic       full_hold   = 1'b0;
    logic       toggle_en   = 1'b0;

    always @(negedge clk) begin
        if (bus.transmit) begin
            tx_log.push_back(bus.tx_byte);
            if (bus.tx_fifo_full) full_viol++;
        end
        if (bus.rx_fifo_pop) begin
            pop_cnt++;
            rd_ptr++;
        end
        if (line_done) done_cnt++;
        if ((bus.transmit || bus.rx_fifo_pop) && strobe_prev) space_viol++;
        strobe_prev = bus.transmit || bus.rx_fifo_pop;
        tog_cnt++;
        if (tog_cnt % 3 == 0) full_tog = !full_tog;
        bus.tx_fifo_full  = toggle_en ? full_tog : full_hold;
        bus.rx_fifo_empty = (rd_ptr >= rx_src.size());
        bus.rx_byte       = bus.rx_fifo_empty ? 8'h00 : rx_src[rd_ptr];
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Wait until all rx bytes are consumed and the engine is idle, bounded.
    task automatic settle();
        int n;
        n = 0;
        while (((rd_ptr < rx_src.size()) || busy) && (n < 300)) begin
            step(1);
            n++;
        end
        check("settle_timeout", 32'(n < 300), 32'd1);
        step(4);
    endtask

    task automatic check_tx(input string tag, input int base);
        check({tag, "_len"}, 32'(tx_log.size() - base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < tx_log.size()) begin
                check($sformatf("%s_b%0d", tag, i), 32'(tx_log[base + i]), 32'(exp_q[i]));
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  tx_base;
        int  pop_base;
        int  done_base;
        bit  seen;

        step(3);
        check("rst_strobes", 32'({bus.rx_fifo_pop, bus.transmit}), 32'd0);
        check("rst_flags",   32'({busy, line_done, ovf}), 32'd0);
        check("rst_fill",    32'(fill), 32'd0);
        check("rst_txbyte",  32'(bus.tx_byte), 32'd0);
        rst_n = 1'b1;
        step(2);

        // 1: byte echo, no case mapping
        tx_base = tx_log.size(); pop_base = pop_cnt;
        rx_src.push_back(8'h61); rx_src.push_back(8'h42);
        settle();
        exp_q = '{8'h61, 8'h42};
        check_tx("t1", tx_base);
        check("t1_pops", 32'(pop_cnt - pop_base), 32'd2);

        // 2: tx full blocks byte echo; release produces echo one cycle later
        tx_base = tx_log.size(); pop_base = pop_cnt;
        full_hold = 1'b1;
        rx_src.push_back(8'h78);
        step(10);
        check("t2_held_tx",   32'(tx_log.size() - tx_base), 32'd0);
        check("t2_held_pops", 32'(pop_cnt - pop_base), 32'd0);
        full_hold = 1'b0;
        @(negedge clk);
        check("t2_not_early", 32'(bus.transmit), 32'd0);
        @(negedge clk);
        check("t2_echo_strobe", 32'({bus.transmit, bus.rx_fifo_pop}), 32'd3);
        check("t2_echo_byte",   32'(bus.tx_byte), 32'h78);
        settle();

        // 3: line mode with upcase and backspace
        line_mode = 1'b1; upcase = 1'b1;
        tx_base = tx_log.size(); done_base = done_cnt;
        rx_src.push_back(8'h61); rx_src.push_back(8'h62);
        rx_src.push_back(8'h08); rx_src.push_back(8'h63);
        settle();
        check("t3_fill_pre", 32'(fill), 32'd2);
        check("t3_no_echo",  32'(tx_log.size() - tx_base), 32'd0);
        rx_src.push_back(8'h0D);
        settle();
        exp_q = '{8'h41, 8'h43, 8'h0D, 8'h0A};
        check_tx("t3", tx_base);
        check("t3_done",  32'(done_cnt - done_base), 32'd1);
        check("t3_fill",  32'(fill), 32'd0);

        // 4: overflow of the 4-entry buffer; line_mode drop mid-line is ignored
        upcase = 1'b0;
        tx_base = tx_log.size(); done_base = done_cnt;
        for (int i = 0; i < 6; i++) rx_src.push_back(8'(8'h31 + i));
        settle();
        check("t4_fill_full", 32'(fill), 32'd4);
        check("t4_ovf_set",   32'(ovf), 32'd1);
        line_mode = 1'b0;
        rx_src.push_back(8'h0D);
        settle();
        exp_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h0D, 8'h0A};
        check_tx("t4", tx_base);
        check("t4_done",      32'(done_cnt - done_base), 32'd1);
        check("t4_ovf_held",  32'(ovf), 32'd1);
        clr_ovf = 1'b1;
        step(1);
        clr_ovf = 1'b0;
        check("t4_ovf_clr",   32'(ovf), 32'd0);
        line_mode = 1'b1;

        // 5: flush with tx_fifo_full toggling; BS on empty buffer ignored; exact fill, no ovf
        tx_base = tx_log.size(); done_base = done_cnt;
        toggle_en = 1'b1;
        rx_src.push_back(8'h08);
        rx_src.push_back(8'h77); rx_src.push_back(8'h78);
        rx_src.push_back(8'h79); rx_src.push_back(8'h7A);
        rx_src.push_back(8'h0D);
        settle();
        toggle_en = 1'b0;
        step(2);
        exp_q = '{8'h77, 8'h78, 8'h79, 8'h7A, 8'h0D, 8'h0A};
        check_tx("t5", tx_base);
        check("t5_done",       32'(done_cnt - done_base), 32'd1);
        check("t5_no_ovf",     32'(ovf), 32'd0);
        check("t5_full_strobe", 32'(full_viol), 32'd0);

        // 6: reset mid-flush, then a bare CR
        rx_src.push_back(8'h70); rx_src.push_back(8'h71); rx_src.push_back(8'h0D);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (bus.transmit) seen = 1'b1;
        end
        check("t6_flush_started", 32'(seen), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_strobes", 32'({bus.rx_fifo_pop, bus.transmit, line_done}), 32'd0);
        check("t6_rst_busy",    32'(busy), 32'd0);
        check("t6_rst_fill",    32'(fill), 32'd0);
        check("t6_rst_txbyte",  32'(bus.tx_byte), 32'd0);
        step(3);
        rst_n = 1'b1;
        tx_base = tx_log.size(); done_base = done_cnt;
        step(3);
        check("t6_quiet_after_rst", 32'(tx_log.size() - tx_base), 32'd0);
        rx_src.push_back(8'h0D);
        settle();
        exp_q = '{8'h0D, 8'h0A};
        check_tx("t6", tx_base);
        check("t6_done", 32'(done_cnt - done_base), 32'd1);
        check("t6_fill", 32'(fill), 32'd0);

        check("strobe_spacing", 32'(space_viol), 32'd0);
        check("full_strobe",    32'(full_viol), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
